// File: rtl/uart_bus_bridge.sv
// UART debug bridge: 'W'/'R' command frames become single-word bus accesses through req/gnt arbitration.
// Waits indefinitely for grant; RX bytes are dropped while an access and its reply are in flight.
module uart_bus_bridge #(
  parameter int BAUD_DIV = 16,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  output logic [1:0]  size_o,
  output logic        rd_o,
  output logic        wr_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_OP, S_ADDR, S_DATA, S_REQ, S_ACC, S_RDCAP, S_RESP} state_t;

  logic            r_rx_s1, r_rx_s2, r_rx_s3;
  rx_state_t       r_rx_state;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_sr;
  logic            r_rx_vld;
  logic [7:0]      r_rx_dat;

  logic [9:0]      r_tx_sr;
  logic [CW-1:0]   r_tx_cnt;
  logic [3:0]      r_tx_bit;
  logic            r_tx_busy;
  logic            w_tx_rdy;
  logic            w_tx_load;

  state_t          r_state;
  logic [7:0]      r_op;
  logic            r_is_wr;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_shift;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_req;
  logic            r_rd;
  logic            r_wr;
  logic [31:0]     r_resp_word;
  logic [2:0]      r_resp_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic            w_to_active;
  logic            w_to_hit;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sr    <= '0;
      r_rx_vld   <= 1'b0;
      r_rx_dat   <= '0;
    end else begin
      r_rx_s1  <= uart_rx_i;
      r_rx_s2  <= r_rx_s1;
      r_rx_s3  <= r_rx_s2;
      r_rx_vld <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_s3 && !r_rx_s2) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (r_rx_cnt == BAUD_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BAUD_LAST) begin
            r_rx_cnt <= '0;
            r_rx_sr  <= {r_rx_s2, r_rx_sr[7:1]};
            r_rx_bit <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == BAUD_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_s2) begin
              r_rx_vld <= 1'b1;
              r_rx_dat <= r_rx_sr;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Accepting a new byte on the final stop-bit cycle keeps reply bytes gapless.
  assign w_tx_rdy  = !r_tx_busy || ((r_tx_cnt == BAUD_LAST) && (r_tx_bit == 4'd9));
  assign w_tx_load = (r_state == S_RESP) && (r_resp_cnt != 3'd0) && w_tx_rdy;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_tx_sr   <= '1;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      r_tx_busy <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_sr   <= {1'b1, r_resp_word[31:24], 1'b0};
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      r_tx_busy <= 1'b1;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == BAUD_LAST) begin
        r_tx_cnt <= '0;
        r_tx_sr  <= {1'b1, r_tx_sr[9:1]};
        if (r_tx_bit == 4'd9) r_tx_busy <= 1'b0;
        else                  r_tx_bit  <= r_tx_bit + 1'b1;
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  assign w_to_active = (r_state == S_OP) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_to_hit    = w_to_active && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)                     r_to_cnt <= '0;
    else if (!w_to_active || r_rx_vld) r_to_cnt <= '0;
    else if (r_to_cnt != TO_LAST)     r_to_cnt <= r_to_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_is_wr     <= 1'b0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req       <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_resp_word <= '0;
      r_resp_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_rx_vld) begin
            r_op    <= r_rx_dat;
            r_state <= S_OP;
          end
        end
        S_OP: begin
          r_byte_cnt <= '0;
          if (r_op == 8'h57 || r_op == 8'h52) begin
            r_is_wr <= (r_op == 8'h57);
            r_state <= S_ADDR;
          end else begin
            r_resp_word <= {8'h3F, 24'h0};
            r_resp_cnt  <= 3'd1;
            r_state     <= S_RESP;
          end
        end
        S_ADDR: begin
          if (r_rx_vld) begin
            r_shift    <= {r_shift[15:0], r_rx_dat};
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == 2'd3) begin
              r_addr <= {r_shift, r_rx_dat[7:2], 2'b00};
              if (r_is_wr) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_REQ;
                r_req   <= 1'b1;
              end
            end
          end else if (w_to_hit) begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (r_rx_vld) begin
            r_shift    <= {r_shift[15:0], r_rx_dat};
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == 2'd3) begin
              r_wdata <= {r_shift, r_rx_dat};
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
          end else if (w_to_hit) begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (gnt_i) begin
            r_state <= S_ACC;
            if (r_is_wr) r_wr <= 1'b1;
            else         r_rd <= 1'b1;
          end
        end
        S_ACC: begin
          // Grant is not re-examined here: the strobe is already on the bus.
          r_rd <= 1'b0;
          r_wr <= 1'b0;
          if (r_is_wr) begin
            r_req       <= 1'b0;
            r_resp_word <= {8'h4B, 24'h0};
            r_resp_cnt  <= 3'd1;
            r_state     <= S_RESP;
          end else begin
            r_state <= S_RDCAP;
          end
        end
        S_RDCAP: begin
          r_resp_word <= rdata_i;
          r_resp_cnt  <= 3'd4;
          r_req       <= 1'b0;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (w_tx_load) begin
            r_resp_word <= {r_resp_word[23:0], 8'h00};
            r_resp_cnt  <= r_resp_cnt - 1'b1;
          end else if (r_resp_cnt == 3'd0 && !r_tx_busy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_tx_o = r_tx_sr[0];
  assign req_o     = r_req;
  assign rd_o      = r_rd;
  assign wr_o      = r_wr;
  assign addr_o    = r_addr;
  assign wdata_o   = r_wdata;
  assign size_o    = 2'b10;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: UART driver/monitor, bus slave, and a memory-level reference model.
module tb_uart_bus_bridge;
  localparam int BD = 16;
  localparam int TO = 1000;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        uart_rx_i;
  logic        uart_tx_o;
  logic        req_o;
  logic        gnt_i;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i;
  logic [1:0]  size_o;
  logic        rd_o;
  logic        wr_o;

  always #5 clk_i = ~clk_i;

  uart_bus_bridge #(.BAUD_DIV(BD), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
    .size_o(size_o), .rd_o(rd_o), .wr_o(wr_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0]  tx_q[$];
  int          tx_t[$];
  bit          ev_wr[$];
  logic [31:0] ev_addr[$];
  logic [31:0] ev_data[$];
  int          req_cycles = 0;
  int          viol = 0;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] wr_list[$];
  bit          prev_rd = 1'b0;
  logic [31:0] rd_addr = 32'h0;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Bus slave and monitor: read data is valid only in the cycle after rd_o.
  initial begin
    rdata_i = 32'h0;
    forever begin
      @(negedge clk_i);
      rdata_i = prev_rd ? (slave_mem.exists(rd_addr) ? slave_mem[rd_addr] : 32'h0) : $urandom;
      if (req_o === 1'b1) req_cycles++;
      if ((rd_o === 1'b1 || wr_o === 1'b1) && (req_o !== 1'b1 || (rd_o === 1'b1 && wr_o === 1'b1))) viol++;
      if (wr_o === 1'b1) begin
        ev_wr.push_back(1'b1); ev_addr.push_back(addr_o); ev_data.push_back(wdata_o);
        slave_mem[addr_o] = wdata_o;
      end
      if (rd_o === 1'b1) begin
        ev_wr.push_back(1'b0); ev_addr.push_back(addr_o); ev_data.push_back(32'h0);
        rd_addr = addr_o;
      end
      prev_rd = (rd_o === 1'b1);
    end
  end

  // UART receiver on the reply line.
  initial begin
    logic [7:0] b;
    int t;
    forever begin
      @(negedge uart_tx_o);
      @(negedge clk_i);
      t = cyc;
      repeat (BD/2 - 1) @(negedge clk_i);
      if (uart_tx_o === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk_i);
          b[i] = uart_tx_o;
        end
        repeat (BD) @(negedge clk_i);
        tx_q.push_back(b);
        tx_t.push_back(t);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk_i);
    errors++;
    $display("FAIL watchdog: got cycle %0d, required finish before it", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  task automatic clear_logs();
    tx_q.delete(); tx_t.delete();
    ev_wr.delete(); ev_addr.delete(); ev_data.delete();
    req_cycles = 0; viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk_i);
    uart_rx_i = 1'b0;
    repeat (BD) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (BD) @(negedge clk_i);
    end
    uart_rx_i = !bad_stop;
    repeat (BD) @(negedge clk_i);
    uart_rx_i = 1'b1;
    if (bad_stop) repeat (BD) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [71:0] bytes, input int n);
    for (int i = 0; i < n; i++) send_byte(bytes[8*(n-1-i) +: 8], 1'b0);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n*200 + 400; i++) begin
      if (tx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    repeat (20) @(negedge clk_i);
  endtask

  task automatic test_reset();
    reset_i = 1'b0; uart_rx_i = 1'b1; gnt_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", uart_tx_o); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", req_o); end
    checks++; if (rd_o !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b required 0", rd_o); end
    checks++; if (wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b required 0", wr_o); end
    checks++; if (addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", addr_o); end
    checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", wdata_o); end
    checks++; if (size_o !== 2'b10) begin errors++; $display("FAIL reset_size: got %b required 10", size_o); end
    reset_i = 1'b1;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_write();
    bit ok;
    clear_logs();
    send_frame(72'h57_00_00_00_12_DE_AD_BE_EF, 9);
    wait_tx(1, ok);
    model_mem[32'h10] = 32'hDEADBEEF;
    checks++; if (!ok) begin errors++; $display("FAIL write_reply_timeout: got %0d bytes required 1", tx_q.size()); end
    checks++; if (ev_wr.size() != 1) begin errors++; $display("FAIL write_strobes: got %0d required 1", ev_wr.size()); end
    if (ev_wr.size() > 0) begin
      checks++; if (ev_wr[0] !== 1'b1) begin errors++; $display("FAIL write_kind: got rd required wr"); end
      checks++; if (ev_addr[0] !== 32'h10) begin errors++; $display("FAIL write_addr: got %h required 00000010", ev_addr[0]); end
      checks++; if (ev_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data: got %h required deadbeef", ev_data[0]); end
    end
    checks++; if (size_o !== 2'b10) begin errors++; $display("FAIL write_size: got %b required 10", size_o); end
    if (tx_q.size() > 0) begin
      checks++; if (tx_q[0] !== 8'h4B) begin errors++; $display("FAIL write_reply: got %h required 4b", tx_q[0]); end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL write_protocol: got %0d violations required 0", viol); end
  endtask

  task automatic test_read();
    bit ok;
    logic [31:0] exp_w;
    exp_w = 32'h12345678;
    slave_mem[32'h10] = exp_w;
    model_mem[32'h10] = exp_w;
    clear_logs();
    send_frame(72'h52_00_00_00_10, 5);
    wait_tx(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_reply_timeout: got %0d bytes required 4", tx_q.size()); end
    checks++; if (ev_wr.size() != 1) begin errors++; $display("FAIL read_strobes: got %0d required 1", ev_wr.size()); end
    if (ev_wr.size() > 0) begin
      checks++; if (ev_wr[0] !== 1'b0 || ev_addr[0] !== 32'h10) begin
        errors++; $display("FAIL read_access: got wr=%b addr=%h required rd at 00000010", ev_wr[0], ev_addr[0]);
      end
    end
    for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
      checks++; if (tx_q[i] !== exp_w[31-8*i -: 8]) begin
        errors++; $display("FAIL read_byte%0d: got %h required %h", i, tx_q[i], exp_w[31-8*i -: 8]);
      end
    end
    for (int i = 1; i < tx_t.size(); i++) begin
      checks++; if (tx_t[i] - tx_t[i-1] != BD*10) begin
        errors++; $display("FAIL read_gap%0d: got %0d clocks required %0d", i, tx_t[i] - tx_t[i-1], BD*10);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit seen;
    clear_logs();
    gnt_i = 1'b0;
    send_frame(72'h57_00_00_01_00_CA_FE_F0_0D, 9);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (req_o === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk_i);
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_req_rise: got %b required 1", req_o); end
    repeat (200) @(negedge clk_i);
    checks++; if (ev_wr.size() != 0 || req_o !== 1'b1) begin
      errors++; $display("FAIL stall_hold: got %0d strobes req=%b required 0 strobes req=1", ev_wr.size(), req_o);
    end
    gnt_i = 1'b1;
    @(negedge clk_i);
    checks++; if (wr_o !== 1'b1 || req_o !== 1'b1) begin errors++; $display("FAIL stall_strobe: got wr=%b req=%b required 1 1", wr_o, req_o); end
    @(negedge clk_i);
    checks++; if (wr_o !== 1'b0 || req_o !== 1'b0) begin errors++; $display("FAIL stall_release: got wr=%b req=%b required 0 0", wr_o, req_o); end
    wait_tx(1, ok);
    model_mem[32'h100] = 32'hCAFEF00D;
    checks++; if (!ok || tx_q[0] !== 8'h4B) begin errors++; $display("FAIL stall_reply: got %0d bytes required one 4b", tx_q.size()); end
    checks++; if (ev_wr.size() != 1 || ev_addr[0] !== 32'h100 || ev_data[0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL stall_access: got %0d strobes required one write cafef00d at 00000100", ev_wr.size());
    end
  endtask

  task automatic test_bad_op();
    bit ok;
    clear_logs();
    send_byte(8'h41, 1'b0);
    wait_tx(1, ok);
    checks++; if (!ok || tx_q[0] !== 8'h3F) begin errors++; $display("FAIL badop_reply: got %0d bytes required one 3f", tx_q.size()); end
    checks++; if (ev_wr.size() != 0 || req_cycles != 0) begin
      errors++; $display("FAIL badop_bus: got %0d strobes %0d req cycles required 0 0", ev_wr.size(), req_cycles);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [31:0] exp_w;
    clear_logs();
    send_frame(72'h57_00, 2);
    repeat (1100) @(negedge clk_i);
    checks++; if (tx_q.size() != 0 || req_cycles != 0) begin
      errors++; $display("FAIL timeout_silent: got %0d bytes %0d req cycles required 0 0", tx_q.size(), req_cycles);
    end
    exp_w = model_read(32'h100);
    send_frame(72'h52_00_00_01_03, 5);
    wait_tx(4, ok);
    checks++; if (!ok || ev_wr.size() != 1) begin errors++; $display("FAIL timeout_recover: got %0d strobes required 1", ev_wr.size()); end
    if (ev_wr.size() > 0) begin
      checks++; if (ev_wr[0] !== 1'b0 || ev_addr[0] !== 32'h100) begin
        errors++; $display("FAIL timeout_access: got wr=%b addr=%h required rd at 00000100", ev_wr[0], ev_addr[0]);
      end
    end
    for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
      checks++; if (tx_q[i] !== exp_w[31-8*i -: 8]) begin
        errors++; $display("FAIL timeout_byte%0d: got %h required %h", i, tx_q[i], exp_w[31-8*i -: 8]);
      end
    end
  endtask

  task automatic test_robust();
    bit ok;
    bit seen;
    logic [31:0] exp_w;
    clear_logs();
    exp_w = model_read(32'h10);
    send_frame(72'h52_00_00, 3);
    send_byte(8'h00, 1'b1);
    send_frame(72'h00_10, 2);
    wait_tx(4, ok);
    checks++; if (!ok || ev_wr.size() != 1 || tx_q.size() != 4) begin
      errors++; $display("FAIL framing_drop: got %0d strobes %0d bytes required 1 4", ev_wr.size(), tx_q.size());
    end
    if (ev_wr.size() > 0) begin
      checks++; if (ev_addr[0] !== 32'h10) begin errors++; $display("FAIL framing_addr: got %h required 00000010", ev_addr[0]); end
    end
    if (tx_q.size() > 3) begin
      checks++; if ({tx_q[0], tx_q[1], tx_q[2], tx_q[3]} !== exp_w) begin
        errors++; $display("FAIL framing_data: got %h%h%h%h required %h", tx_q[0], tx_q[1], tx_q[2], tx_q[3], exp_w);
      end
    end
    clear_logs();
    send_frame(72'h52_00_00_00_10, 5);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (uart_tx_o === 1'b0) begin seen = 1'b1; break; end
      @(negedge clk_i);
    end
    repeat (40) @(negedge clk_i);
    clear_logs();
    reset_i = 1'b0;
    #1;
    checks++; if (!seen || uart_tx_o !== 1'b1) begin errors++; $display("FAIL midtx_reset_tx: got %b required 1", uart_tx_o); end
    checks++; if (req_o !== 1'b0 || addr_o !== 32'h0) begin errors++; $display("FAIL midtx_reset_bus: got req=%b addr=%h required 0 0", req_o, addr_o); end
    repeat (5) @(negedge clk_i);
    reset_i = 1'b1;
    repeat (300) @(negedge clk_i);
    checks++; if (ev_wr.size() != 0) begin errors++; $display("FAIL midtx_no_strobe: got %0d required 0", ev_wr.size()); end
  endtask

  task automatic test_random();
    bit ok;
    logic [71:0] fr;
    logic [7:0] op;
    logic [31:0] a, d, exp_w;
    int kind, n;
    for (int k = 0; k < 10; k++) begin
      clear_logs();
      kind = $urandom_range(0, 2);
      a = $urandom;
      d = $urandom;
      if (kind == 1 && wr_list.size() > 0 && $urandom_range(0, 9) < 7)
        a = wr_list[$urandom_range(0, wr_list.size()-1)] | 32'($urandom_range(0, 3));
      if (kind == 0) begin fr = {8'h57, a, d, 24'h0} >> 0; fr = {8'h57, a, d}; n = 9; end
      else if (kind == 1) begin fr = {32'h0, 8'h52, a}; n = 5; end
      else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        fr = {64'h0, op}; n = 1;
      end
      gnt_i = ($urandom_range(0, 1) == 0);
      send_frame(fr, n);
      if (!gnt_i) begin
        repeat ($urandom_range(5, 60)) @(negedge clk_i);
        gnt_i = 1'b1;
      end
      a = a & 32'hFFFF_FFFC;
      if (kind == 0) begin
        model_mem[a] = d;
        wr_list.push_back(a);
        wait_tx(1, ok);
        checks++; if (!ok || tx_q[0] !== 8'h4B) begin errors++; $display("FAIL rand%0d_wreply: got %0d bytes required one 4b", k, tx_q.size()); end
        checks++; if (ev_wr.size() != 1 || ev_wr[0] !== 1'b1 || ev_addr[0] !== a || ev_data[0] !== d) begin
          errors++; $display("FAIL rand%0d_write: got %0d strobes required one write %h at %h", k, ev_wr.size(), d, a);
        end
      end else if (kind == 1) begin
        exp_w = model_read(a);
        wait_tx(4, ok);
        checks++; if (!ok || tx_q.size() != 4 || {tx_q[0], tx_q[1], tx_q[2], tx_q[3]} !== exp_w) begin
          errors++; $display("FAIL rand%0d_rdata: got %0d bytes required %h", k, tx_q.size(), exp_w);
        end
        checks++; if (ev_wr.size() != 1 || ev_wr[0] !== 1'b0 || ev_addr[0] !== a) begin
          errors++; $display("FAIL rand%0d_read: got %0d strobes required one read at %h", k, ev_wr.size(), a);
        end
      end else begin
        wait_tx(1, ok);
        checks++; if (!ok || tx_q[0] !== 8'h3F || ev_wr.size() != 0 || req_cycles != 0) begin
          errors++; $display("FAIL rand%0d_badop: got %0d bytes %0d strobes required one 3f no strobes", k, tx_q.size(), ev_wr.size());
        end
      end
      checks++; if (viol != 0) begin errors++; $display("FAIL rand%0d_protocol: got %0d violations required 0", k, viol); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_bad_op();
    test_timeout();
    test_robust();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
